// File: rtl/hilo_muldiv_unit.sv
// Iterative Hi/Lo multiply/divide unit; the divider datapath is compiled in only when HILO_DIV_EN is defined.
// Latency WIDTH+1 cycles (1 for divide-by-zero or disabled divide); Start and direct writes are ignored while Busy.
module hilo_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Hi_we,
    input  logic             Lo_we,
    input  logic [WIDTH-1:0] Hi_in,
    input  logic [WIDTH-1:0] Lo_in,
    output logic [WIDTH-1:0] Hi_out,
    output logic [WIDTH-1:0] Lo_out,
    output logic             Busy,
    output logic             Done,
    output logic             DivByZero
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             neg_q, neg_d;
    logic             skip_q, skip_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;

    // Operands are reduced to magnitudes up front; the sign is reapplied at retire.
    logic             is_signed, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    assign is_signed = ~Op[0];
    assign a_neg     = is_signed & A[WIDTH-1];
    assign b_neg     = is_signed & B[WIDTH-1];
    assign a_mag     = a_neg ? (~A + 1'b1) : A;
    assign b_mag     = b_neg ? (~B + 1'b1) : B;

    // Shift-add: acc_lo holds the multiplier and fills with product bits from the top.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_prod, mul_res;

    assign mul_sum  = {1'b0, acc_hi_q} + {1'b0, opnd_q & {WIDTH{acc_lo_q[0]}}};
    assign mul_prod = {acc_hi_q, acc_lo_q};
    assign mul_res  = neg_q ? (~mul_prod + 1'b1) : mul_prod;

`ifdef HILO_DIV_EN
    logic             is_div_q, is_div_d;
    logic             rem_neg_q, rem_neg_d;
    logic             dz_pend_q, dz_pend_d;
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_diff, quo_res, rem_res;

    // Restoring step: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in.
    assign div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, opnd_q};
    assign div_diff  = div_shift[WIDTH-1:0] - opnd_q;
    assign quo_res   = neg_q ? (~acc_lo_q + 1'b1) : acc_lo_q;
    assign rem_res   = rem_neg_q ? (~acc_hi_q + 1'b1) : acc_hi_q;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        opnd_d   = opnd_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        neg_d    = neg_q;
        skip_d   = skip_q;
        done_d   = 1'b0;
        dbz_d    = 1'b0;
`ifdef HILO_DIV_EN
        is_div_d  = is_div_q;
        rem_neg_d = rem_neg_q;
        dz_pend_d = dz_pend_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (Hi_we) hi_d = Hi_in;
                if (Lo_we) lo_d = Lo_in;
                if (Start) begin
                    cnt_d    = '0;
                    neg_d    = a_neg ^ b_neg;
                    skip_d   = 1'b0;
                    acc_hi_d = '0;
`ifdef HILO_DIV_EN
                    is_div_d  = Op[1];
                    rem_neg_d = a_neg;
                    dz_pend_d = 1'b0;
                    if (Op[1]) begin
                        acc_lo_d = a_mag;
                        opnd_d   = b_mag;
                        if (B == '0) begin
                            state_d   = S_FINISH;
                            skip_d    = 1'b1;
                            dz_pend_d = 1'b1;
                        end else begin
                            state_d = S_RUN;
                        end
                    end else begin
                        acc_lo_d = b_mag;
                        opnd_d   = a_mag;
                        state_d  = S_RUN;
                    end
`else
                    acc_lo_d = b_mag;
                    opnd_d   = a_mag;
                    if (Op[1]) begin
                        state_d = S_FINISH;
                        skip_d  = 1'b1;
                    end else begin
                        state_d = S_RUN;
                    end
`endif
                end
            end
            S_RUN: begin
                cnt_d = cnt_q + 1'b1;
`ifdef HILO_DIV_EN
                if (is_div_q) begin
                    acc_hi_d = div_ge ? div_diff : div_shift[WIDTH-1:0];
                    acc_lo_d = {acc_lo_q[WIDTH-2:0], div_ge};
                end else begin
                    {acc_hi_d, acc_lo_d} = {mul_sum, acc_lo_q[WIDTH-1:1]};
                end
`else
                {acc_hi_d, acc_lo_d} = {mul_sum, acc_lo_q[WIDTH-1:1]};
`endif
                if (cnt_q == LAST_CNT) state_d = S_FINISH;
            end
            S_FINISH: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
`ifdef HILO_DIV_EN
                dbz_d = dz_pend_q;
                if (!skip_q) begin
                    if (is_div_q) begin
                        hi_d = rem_res;
                        lo_d = quo_res;
                    end else begin
                        {hi_d, lo_d} = mul_res;
                    end
                end
`else
                if (!skip_q) {hi_d, lo_d} = mul_res;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            opnd_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            neg_q    <= 1'b0;
            skip_q   <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
`ifdef HILO_DIV_EN
            is_div_q  <= 1'b0;
            rem_neg_q <= 1'b0;
            dz_pend_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            opnd_q   <= opnd_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            neg_q    <= neg_d;
            skip_q   <= skip_d;
            done_q   <= done_d;
            dbz_q    <= dbz_d;
`ifdef HILO_DIV_EN
            is_div_q  <= is_div_d;
            rem_neg_q <= rem_neg_d;
            dz_pend_q <= dz_pend_d;
`endif
        end
    end

    assign Hi_out    = hi_q;
    assign Lo_out    = lo_q;
    assign Busy      = (state_q != S_IDLE);
    assign Done      = done_q;
    assign DivByZero = dbz_q;

endmodule

// File: doc/hilo_muldiv_unit.md
HILO_MULDIV_UNIT -- requirements
Module: hilo_muldiv_unit

Interface
REQ-001 Parameter: WIDTH, default 32, operand and Hi/Lo register width; legal values 8..64.
REQ-002 Clk  input  1  single clock; all state updates on posedge Clk.
REQ-003 Rst_n  input  1  reset; synchronous, active-low.
REQ-004 Start  input  1  launch operation selected by Op; sampled only in IDLE.
REQ-005 Op  input  2  00 MULT signed, 01 MULTU, 10 DIV signed, 11 DIVU.
REQ-006 A, B  input  WIDTH each  operands: multiplicand/multiplier or dividend/divisor.
REQ-007 Hi_we, Lo_we  input  1 each  direct write enables (MTHI/MTLO).
REQ-008 Hi_in, Lo_in  input  WIDTH each  direct write data.
REQ-009 Hi_out, Lo_out  output  WIDTH each  registered Hi/Lo contents.
REQ-010 Busy  output  1  high while an operation is in flight.
REQ-011 Done  output  1  one-cycle pulse when an operation retires.
REQ-012 DivByZero  output  1  one-cycle pulse, coincident with Done, for divide with B==0.

Function
REQ-013 States: IDLE, RUN, FINISH; IDLE->RUN on Start; RUN->FINISH after WIDTH iteration cycles; FINISH->IDLE unconditionally.
REQ-014 Start at edge E0 -> Busy=1 after E0; Hi/Lo update, Busy=0, Done=1 after edge E0+WIDTH+1; latency WIDTH+1 cycles.
REQ-015 Operands latched at E0; changes to A/B/Op after E0 have no effect on the result.
REQ-016 Multiply: iterative shift-add on magnitudes; signed result negated when operand signs differ; Hi = upper WIDTH bits, Lo = lower WIDTH bits of 2*WIDTH product.
REQ-017 Divide: iterative restoring on magnitudes; Lo = quotient, Hi = remainder; signed quotient truncates toward zero, remainder takes the dividend's sign.
REQ-018 Signed divide of most-negative by -1: Lo = most-negative value (wrap), Hi = 0, no flag.
REQ-019 Divide with B==0: RUN skipped, IDLE->FINISH; Done and DivByZero pulse after E0+1; Hi/Lo unchanged.
REQ-020 Start while Busy: ignored, no queueing.
REQ-021 Hi_we/Lo_we in IDLE: Hi_out/Lo_out take Hi_in/Lo_in at next edge; independent per half.
REQ-022 Hi_we/Lo_we while Busy (RUN or FINISH): ignored.
REQ-023 Start and Hi_we/Lo_we same IDLE edge: direct write applies; operation result later overwrites both halves.
REQ-024 Done and DivByZero are 0 in all cycles other than the one following FINISH.

Reset
REQ-025 Rst_n low at a posedge: Hi_out=0, Lo_out=0, Busy=0, Done=0, DivByZero=0, state IDLE.
REQ-026 Reset mid-operation aborts it; no Done, no Hi/Lo update from the aborted operation.
REQ-027 Start, Hi_we, Lo_we ignored on any edge where Rst_n is low.

Configuration
REQ-028 Macro HILO_DIV_EN defined: divider datapath compiled in; Op 10/11 behave per REQ-017..REQ-019.
REQ-029 HILO_DIV_EN undefined: no divider logic; Start with Op 10/11 goes IDLE->FINISH, Done pulses after E0+1, Hi/Lo unchanged, DivByZero stays 0.

Verification (WIDTH=32, HILO_DIV_EN defined unless noted)
REQ-030 MULT A=0xFFFFFFFD (-3), B=5 -> after 33 cycles Hi=0xFFFFFFFF, Lo=0xFFFFFFF1, Done one cycle.
REQ-031 DIV A=0xFFFFFFF9 (-7), B=2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF; DIVU A=100, B=7 -> Lo=14, Hi=2.
REQ-032 DIVU A=5, B=0 with Hi=0x11, Lo=0x22 -> Done and DivByZero after 1 cycle, Hi=0x11, Lo=0x22 unchanged.
REQ-033 MULTU 0xFFFFFFFF*0xFFFFFFFF, Rst_n low at cycle 10 -> all outputs 0, no Done; following MTHI 0xABCD -> Hi=0xABCD next cycle.
REQ-034 Start and Hi_we=1 (Hi_in=0x55) during MULT in flight -> both ignored, result unchanged; same with HILO_DIV_EN undefined and Op=10 -> Done after 1 cycle, Hi/Lo unchanged.
